// File: rtl/pipe_skid_pkg.sv
// Shared state encoding and widths for the elastic pipeline slice.
package pipe_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_BUSY  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  localparam int OCC_W = 2;

endpackage

// File: rtl/pipe_skid.sv
// Two-entry valid/ready slice (main + skid): beats land on q one cycle after take, 1 beat/cycle.
// Backpressure: ready_out is a pure decode of registered state, so ready_in never reaches it combinationally.
module pipe_skid
  import pipe_pkg::*;
#(
  parameter type T = logic [31:0]
) (
  input  logic             clk,
  input  logic             async_rst_n,
  input  logic             sync_rst_n,
  input  logic             flush,
  input  T                 d,
  input  logic             valid_in,
  output logic             ready_out,
  output T                 q,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [OCC_W-1:0] occupancy
);

  skid_state_e state_q, state_d;
  T            main_q, main_d;
  T            skid_q, skid_d;

  logic take;
  logic drop;

  assign take = valid_in && ready_out;
  assign drop = valid_out && ready_in;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      SKID_EMPTY: begin
        if (take) begin
          state_d = SKID_BUSY;
          main_d  = d;
        end
      end
      SKID_BUSY: begin
        if (take && drop) begin
          main_d = d;
        end else if (take) begin
          state_d = SKID_FULL;
          skid_d  = d;
        end else if (drop) begin
          // main keeps its stale payload; only valid_out falls
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (ready_in) begin
          state_d = SKID_BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    if (!sync_rst_n || flush) begin
      state_d = SKID_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q <= SKID_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Illegal encodings present as EMPTY on the outputs as well.
  always_comb begin
    valid_out = 1'b0;
    ready_out = 1'b1;
    occupancy = '0;
    unique case (state_q)
      SKID_BUSY: begin
        valid_out = 1'b1;
        occupancy = OCC_W'(1);
      end
      SKID_FULL: begin
        valid_out = 1'b1;
        ready_out = 1'b0;
        occupancy = OCC_W'(2);
      end
      default: ;
    endcase
  end

  assign q = main_q;

endmodule

// File: tb/tb_pipe_skid.sv
// Directed vector bench for pipe_skid: inputs driven on negedge, outputs sampled 1ns after posedge.
module tb_pipe_skid;

  logic        clk = 1'b0;
  logic        async_rst_n;
  logic        sync_rst_n;
  logic        flush;
  logic [31:0] d;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] q;
  logic        valid_out;
  logic        ready_in;
  logic [1:0]  occupancy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_skid dut (
    .clk        (clk),
    .async_rst_n(async_rst_n),
    .sync_rst_n (sync_rst_n),
    .flush      (flush),
    .d          (d),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .q          (q),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .occupancy  (occupancy)
  );

  typedef struct {
    logic        srst_n;
    logic        flsh;
    logic        vin;
    logic [31:0] din;
    logic        rin;
    logic [31:0] exp_q;
    logic        exp_vo;
    logic        exp_ro;
    logic [1:0]  exp_occ;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] eq, input logic evo,
                         input logic ero, input logic [1:0] eocc);
    chk({tag, ".q"}, q, eq);
    chk({tag, ".valid_out"}, {31'd0, valid_out}, {31'd0, evo});
    chk({tag, ".ready_out"}, {31'd0, ready_out}, {31'd0, ero});
    chk({tag, ".occupancy"}, {30'd0, occupancy}, {30'd0, eocc});
  endtask

  initial begin
    //              srst flush vin  d             rin  q             vo    ro    occ
    // reset release: first take lands, then drains
    vq.push_back('{1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 2'd1});
    vq.push_back('{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 2'd0});
    // streaming
    vq.push_back('{1'b1, 1'b0, 1'b1, 32'h1,        1'b1, 32'h1,        1'b1, 1'b1, 2'd1});
    vq.push_back('{1'b1, 1'b0, 1'b1, 32'h2,        1'b1, 32'h2,        1'b1, 1'b1, 2'd1});
    vq.push_back('{1'b1, 1'b0, 1'b1, 32'h3,        1'b1, 32'h3,        1'b1, 1'b1, 2'd1});
    vq.push_back('{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h3,        1'b0, 1'b1, 2'd0});
    // backpressure fill then drain
    vq.push_back('{1'b1, 1'b0, 1'b1, 32'hA,        1'b0, 32'hA,        1'b1, 1'b1, 2'd1});
    vq.push_back('{1'b1, 1'b0, 1'b1, 32'hB,        1'b0, 32'hA,        1'b1, 1'b0, 2'd2});
    vq.push_back('{1'b1, 1'b0, 1'b1, 32'hB,        1'b0, 32'hA,        1'b1, 1'b0, 2'd2});
    vq.push_back('{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'hB,        1'b1, 1'b1, 2'd1});
    vq.push_back('{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'hB,        1'b0, 1'b1, 2'd0});
    // simultaneous take+drop in BUSY
    vq.push_back('{1'b1, 1'b0, 1'b1, 32'h5,        1'b0, 32'h5,        1'b1, 1'b1, 2'd1});
    vq.push_back('{1'b1, 1'b0, 1'b1, 32'h6,        1'b1, 32'h6,        1'b1, 1'b1, 2'd1});
    // flush while FULL
    vq.push_back('{1'b1, 1'b0, 1'b1, 32'h9,        1'b0, 32'h6,        1'b1, 1'b0, 2'd2});
    vq.push_back('{1'b1, 1'b1, 1'b1, 32'h7,        1'b0, 32'h0,        1'b0, 1'b1, 2'd0});
    // flush while BUSY: beat offered with ready_out=1 is still dropped
    vq.push_back('{1'b1, 1'b0, 1'b1, 32'h8,        1'b0, 32'h8,        1'b1, 1'b1, 2'd1});
    vq.push_back('{1'b1, 1'b1, 1'b1, 32'h7,        1'b0, 32'h0,        1'b0, 1'b1, 2'd0});
    vq.push_back('{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 1'b1, 2'd0});
    vq.push_back('{1'b1, 1'b0, 1'b1, 32'h8,        1'b1, 32'h8,        1'b1, 1'b1, 2'd1});
    // sync reset while FULL
    vq.push_back('{1'b1, 1'b0, 1'b1, 32'hC,        1'b0, 32'h8,        1'b1, 1'b0, 2'd2});
    vq.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 2'd0});
    // sync reset and flush together while FULL
    vq.push_back('{1'b1, 1'b0, 1'b1, 32'hD,        1'b0, 32'hD,        1'b1, 1'b1, 2'd1});
    vq.push_back('{1'b1, 1'b0, 1'b1, 32'hE,        1'b0, 32'hD,        1'b1, 1'b0, 2'd2});
    vq.push_back('{1'b0, 1'b1, 1'b1, 32'hF,        1'b0, 32'h0,        1'b0, 1'b1, 2'd0});
    vq.push_back('{1'b1, 1'b0, 1'b1, 32'h11,       1'b1, 32'h11,       1'b1, 1'b1, 2'd1});
    vq.push_back('{1'b1, 1'b0, 1'b1, 32'h12,       1'b0, 32'h11,       1'b1, 1'b0, 2'd2});

    async_rst_n = 1'b0;
    sync_rst_n  = 1'b1;
    flush       = 1'b0;
    valid_in    = 1'b1;
    d           = 32'hDEADBEEF;
    ready_in    = 1'b0;

    // reset held across clock edges with a beat offered
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 32'h0, 1'b0, 1'b1, 2'd0);

    @(negedge clk);
    async_rst_n = 1'b1;

    foreach (vq[i]) begin
      sync_rst_n = vq[i].srst_n;
      flush      = vq[i].flsh;
      valid_in   = vq[i].vin;
      d          = vq[i].din;
      ready_in   = vq[i].rin;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vq[i].exp_q, vq[i].exp_vo, vq[i].exp_ro, vq[i].exp_occ);
      @(negedge clk);
    end

    // async reset mid-cycle while FULL acts without a clock edge
    valid_in   = 1'b0;
    ready_in   = 1'b1;
    sync_rst_n = 1'b1;
    flush      = 1'b0;
    #2;
    async_rst_n = 1'b0;
    #1;
    chk_all("async_mid", 32'h0, 1'b0, 1'b1, 2'd0);
    @(negedge clk);
    async_rst_n = 1'b1;
    // skid contents must also be gone: nothing emerges afterwards
    @(posedge clk);
    #1;
    chk_all("async_after", 32'h0, 1'b0, 1'b1, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
